mac_job_sequencer: RTL and testbench

//  Sequences multi-chunk int8 dot products on one 8-lane MAC instance (2-stage pipeline, 19-bit signed result).

---
 rtl/mac_job_sequencer.sv | 106 ++++++++++
 tb/tb_mac_job_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer
// Feeds one multi-chunk int8 dot-product job through an external 8-lane MAC.
// Upstream operand chunks are admitted one per cycle with valid/ready. The MAC
// pipeline latency is tracked with a valid shift register, and the MAC results
// are summed into a wide signed accumulator. The final sum is presented on a
// valid/ready result port.
module mac_job_sequencer #(
  parameter int LEN_W   = 8,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_busy,
  input  logic                    i_op_valid,
  output logic                    o_op_ready,
  input  logic [63:0]             i_a,
  input  logic [63:0]             i_b,
  output logic [63:0]             o_mac_a,
  output logic [63:0]             o_mac_b,
  input  logic signed [18:0]      i_mac_res,
  output logic signed [ACC_W-1:0] o_res,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic                    o_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        issued;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] res_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [MAC_LAT-1:0]      vpipe;
  logic                    acc_fire;
  logic                    pipe_out;
  logic                    tail_empty;
  logic                    sum_ovf;

  // Handshake and MAC operand gating; idle cycles feed zeros so they add nothing.
  assign o_op_ready = (state == RUN) && (issued < len);
  assign acc_fire   = i_op_valid && o_op_ready;
  assign o_mac_a    = acc_fire ? i_a : '0;
  assign o_mac_b    = acc_fire ? i_b : '0;
  assign o_busy      = (state != IDLE);
  assign o_res_valid = (state == DONE);

  // Accumulator datapath: sign-extended MAC result, wrap-around sum, overflow detect.
  assign res_ext    = {{(ACC_W-19){i_mac_res[18]}}, i_mac_res};
  assign acc_sum    = acc + res_ext;
  assign sum_ovf    = (acc[ACC_W-1] == res_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
  assign pipe_out   = vpipe[MAC_LAT-1];
  // Only the output stage may still be occupied: after this edge the pipe is empty.
  assign tail_empty = ((vpipe & ~(MAC_LAT'(1) << (MAC_LAT-1))) == '0);

  // Next-state decode for the job FSM.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = (i_len == '0) ? DONE : RUN;
      RUN:     if (acc_fire && (LEN_W'(issued + 1'b1) == len)) state_nx = DRAIN;
      DRAIN:   if (tail_empty) state_nx = DONE;
      DONE:    if (i_res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, chunk counter, latency pipe, accumulator and result capture.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state  <= IDLE;
      len    <= '0;
      issued <= '0;
      acc    <= '0;
      o_ovf  <= 1'b0;
      o_res  <= '0;
      vpipe  <= '0;
    end else begin
      state <= state_nx;
      vpipe <= MAC_LAT'({vpipe, acc_fire});
      if (state == IDLE) begin
        if (i_start) begin
          len    <= i_len;
          issued <= '0;
          acc    <= '0;
          o_ovf  <= 1'b0;
          if (i_len == '0) o_res <= '0;
        end
      end else begin
        if (acc_fire) issued <= issued + 1'b1;
        if (pipe_out) begin
          acc <= acc_sum;
          if (sum_ovf) o_ovf <= 1'b1;
        end
        if (state == DRAIN && tail_empty) o_res <= pipe_out ? acc_sum : acc;
      end
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Testbench for mac_job_sequencer: a 2-stage MAC model drives i_mac_res, and a
// job-level reference model predicts the handshake, result and overflow on
// every cycle for a 32-bit and a 20-bit accumulator instance.
module tb_mac_job_sequencer;

  localparam int MAC_LAT = 2;

  logic               clk = 1'b0;
  logic               rst, start, op_valid, res_ready;
  logic [7:0]         len_in;
  logic [63:0]        a, b;
  logic signed [18:0] mac_res, mac_p1;

  logic               busy0, ready0, res_valid0, ovf0;
  logic [63:0]        mac_a0, mac_b0;
  logic signed [31:0] res0;
  logic               busy1, ready1, res_valid1, ovf1;
  logic [63:0]        mac_a1, mac_b1;
  logic signed [19:0] res1;

  int total = 0;
  int bad   = 0;
  int stepn = 0;

  logic [63:0] ca [256];
  logic [63:0] cb [256];

  mac_job_sequencer #(.LEN_W(8), .ACC_W(32), .MAC_LAT(MAC_LAT)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len_in), .o_busy(busy0),
    .i_op_valid(op_valid), .o_op_ready(ready0), .i_a(a), .i_b(b),
    .o_mac_a(mac_a0), .o_mac_b(mac_b0), .i_mac_res(mac_res), .o_res(res0),
    .o_res_valid(res_valid0), .i_res_ready(res_ready), .o_ovf(ovf0));

  mac_job_sequencer #(.LEN_W(8), .ACC_W(20), .MAC_LAT(MAC_LAT)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len_in), .o_busy(busy1),
    .i_op_valid(op_valid), .o_op_ready(ready1), .i_a(a), .i_b(b),
    .o_mac_a(mac_a1), .o_mac_b(mac_b1), .i_mac_res(mac_res), .o_res(res1),
    .o_res_valid(res_valid1), .i_res_ready(res_ready), .o_ovf(ovf1));

  always #5 clk = ~clk;

  function automatic longint dot(input logic [63:0] x, input logic [63:0] y);
    longint s = 0;
    for (int k = 0; k < 8; k++)
      s += longint'($signed(x[8*k +: 8])) * longint'($signed(y[8*k +: 8]));
    return s;
  endfunction

  function automatic longint wrap(input longint s, input int n);
    longint m = s & ((longint'(1) << n) - 1);
    if (m >= (longint'(1) << (n - 1))) m -= (longint'(1) << n);
    return m;
  endfunction

  // MAC environment model: result appears MAC_LAT cycles after operands, flushed by reset.
  always @(posedge clk) begin
    if (rst) begin
      mac_p1  <= '0;
      mac_res <= '0;
    end else begin
      mac_p1  <= 19'(dot(mac_a0, mac_b0));
      mac_res <= mac_p1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // Job-level reference model: 0 idle, 1 collecting chunks, 2 waiting for MAC, 3 result shown.
  int     m_mode = 0;
  longint m_len = 0, m_cnt = 0, cyc = 0, m_due = 0;
  longint w32 = 0, w20 = 0, r32 = 0, r20 = 0;
  bit     v32 = 0, v20 = 0;

  task automatic acc_step(inout longint w, inout bit v, input longint d, input int n);
    longint s   = w + d;
    longint lim = longint'(1) << (n - 1);
    if (s >= lim || s < -lim) v = 1'b1;
    w = wrap(s, n);
  endtask

  // Compare every cycle on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    bit     rdy_e, fire_e;
    longint d;
    rdy_e  = (m_mode == 1);
    fire_e = rdy_e && op_valid;
    check("busy",       busy0,      m_mode != 0);
    check("op_ready",   ready0,     rdy_e);
    check("res_valid",  res_valid0, m_mode == 3);
    check("res",        res0,       r32);
    check("mac_a",      mac_a0,     fire_e ? a : 64'd0);
    check("mac_b",      mac_b0,     fire_e ? b : 64'd0);
    check("busy20",     busy1,      m_mode != 0);
    check("op_ready20", ready1,     rdy_e);
    check("res_valid20",res_valid1, m_mode == 3);
    check("res20",      res1,       r20);
    check("mac_a20",    mac_a1,     fire_e ? a : 64'd0);
    if (m_mode == 0 || m_mode == 3) begin
      check("ovf",   ovf0, v32);
      check("ovf20", ovf1, v20);
    end
    if (rst) begin
      m_mode = 0; r32 = 0; r20 = 0; v32 = 0; v20 = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_len = len_in; m_cnt = 0; w32 = 0; w20 = 0; v32 = 0; v20 = 0;
          if (len_in == 0) begin m_mode = 3; r32 = 0; r20 = 0; end
          else m_mode = 1;
        end
        1: if (op_valid) begin
          d = dot(a, b);
          acc_step(w32, v32, d, 32);
          acc_step(w20, v20, d, 20);
          m_cnt++;
          if (m_cnt == m_len) begin m_mode = 2; m_due = cyc + MAC_LAT + 1; end
        end
        2: if (cyc + 1 == m_due) begin m_mode = 3; r32 = w32; r20 = w20; end
        3: if (res_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    stepn++;
  endtask

  // Runs one job up to DONE; mode 0 random data, 1 all 3 x all -2, 2 k x 1 with
  // alternating valid, 3 all -128. Returns accept count and accept-to-valid latency.
  task automatic run_job(input int n, input int mode, input int pct, output int acc_n, output int lat);
    int  k = 0, cnt = 0, last = 0;
    bit  fire;
    for (int i = 0; i < 256; i++) begin
      case (mode)
        1:       begin ca[i] = {8{8'd3}};        cb[i] = {8{8'hFE}}; end
        2:       begin ca[i] = {8{8'(i + 1)}};   cb[i] = {8{8'd1}};  end
        3:       begin ca[i] = {8{8'h80}};       cb[i] = {8{8'h80}}; end
        default: begin ca[i] = {$urandom, $urandom}; cb[i] = {$urandom, $urandom}; end
      endcase
    end
    start = 1'b1; len_in = 8'(n); op_valid = 1'b0;
    step();
    start = 1'b0;
    lat = -1;
    while (!res_valid0 && cnt < 3000) begin
      op_valid = (mode == 2) ? (cnt % 2 == 0) : ($urandom_range(99) < pct);
      a        = op_valid ? ca[k & 255] : {$urandom, $urandom};
      b        = op_valid ? cb[k & 255] : {$urandom, $urandom};
      start    = (mode == 0) && ($urandom_range(15) == 0);
      len_in   = 8'($urandom);
      fire     = op_valid && ready0;
      step();
      cnt++;
      if (fire) begin k++; last = stepn; end
    end
    if (res_valid0 && k > 0) lat = stepn - last + 1;
    start = 1'b0; op_valid = 1'b0;
    if (!res_valid0) check("job_timeout", 0, 1);
    acc_n = k;
  endtask

  task automatic finish_job(input int hold);
    res_ready = 1'b0;
    repeat (hold) step();
    res_ready = 1'b1;
    start     = 1'($urandom_range(1));
    step();
    res_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    int acc_n, lat, n;
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    len_in = '0; a = '0; b = '0;
    repeat (2) step();
    check("rst_busy", busy0, 0);
    check("rst_ready", ready0, 0);
    check("rst_res", res0, 0);
    check("rst_valid", res_valid0, 0);
    check("rst_ovf", ovf0, 0);
    rst = 1'b0;
    step();

    // Single chunk: 8 lanes of 3 * -2.
    run_job(1, 1, 100, acc_n, lat);
    check("single_res", res0, -48);
    check("single_lat", lat, 3);
    finish_job(0);

    // Four chunks with bubbles: 8*(1+2+3+4) = 80, held under backpressure.
    run_job(4, 2, 0, acc_n, lat);
    check("multi_accepts", acc_n, 4);
    check("multi_res", res0, 80);
    finish_job(10);
    check("held_res", res0, 80);
    check("idle_after", busy0, 0);

    // Extremes: 255 chunks of 131072.
    run_job(255, 3, 100, acc_n, lat);
    check("ext_res", res0, 33423360);
    check("ext_ovf", ovf0, 0);
    check("ext_ovf20", ovf1, 1);
    check("ext_res20", res1, -131072);
    finish_job(2);

    // Zero-length job: result in the next cycle.
    start = 1'b1; len_in = 8'd0;
    step();
    start = 1'b0;
    check("zero_valid", res_valid0, 1);
    check("zero_res", res0, 0);
    finish_job(1);

    // Abort mid-job after three accepts.
    start = 1'b1; len_in = 8'd8;
    step();
    start = 1'b0; op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      step();
    end
    op_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("abort_no_valid", res_valid0, 0);
    end

    // Randomised jobs.
    for (int j = 0; j < 30; j++) begin
      n = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 40);
      if (j == 29) n = $urandom_range(100, 255);
      run_job(n, 0, $urandom_range(30, 100), acc_n, lat);
      check("rand_accepts", acc_n, n);
      if (n > 0) check("rand_lat", lat, 3);
      finish_job($urandom_range(4));
      repeat ($urandom_range(2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
